// File: rtl/air_hockey_pkg.sv
// Shared air-hockey definitions: screen limits, link FSM encoding and the
// 24-bit position word layout used by both ends of the player-2 PMOD link.
package air_hockey_pkg;

  localparam int unsigned POS_W        = 12;
  localparam int unsigned PIN_W        = 8;
  localparam int unsigned WORD_W       = 3 * PIN_W;
  localparam int unsigned ERR_W        = 8;
  localparam int unsigned SCREEN_X_MAX = 1023;
  localparam int unsigned SCREEN_Y_MAX = 767;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } link_state_t;

  // Word as it appears on the pins, JA in the top byte
  typedef struct packed {
    logic [PIN_W-1:0] ja;
    logic [PIN_W-1:0] jb;
    logic [PIN_W-1:0] jc;
  } link_word_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } pos_t;

  function automatic link_word_t pack_pos(input pos_t p);
    link_word_t w;
    w.ja = p.y[11:4];
    w.jb = p.x[7:0];
    w.jc = {p.y[3:0], p.x[11:8]};
    return w;
  endfunction

  function automatic pos_t unpack_pos(input link_word_t w);
    pos_t p;
    p.x = {w.jc[3:0], w.jb};
    p.y = {w.ja, w.jc[7:4]};
    return p;
  endfunction

endpackage

// File: rtl/player2_link_rx_if.sv
// Player-2 link bundle: raw PMOD pins in, committed position and link status out.
interface player2_link_rx_if;
  import air_hockey_pkg::*;

  logic [PIN_W-1:0] JA;
  logic [PIN_W-1:0] JB;
  logic [PIN_W-1:0] JC;
  logic [POS_W-1:0] xpos_out_player2;
  logic [POS_W-1:0] ypos_out_player2;
  logic             pos_update;
  logic             link_up;
  logic [ERR_W-1:0] err_cnt;

  // master: whatever drives the pins and consumes the position
  modport master (
    output JA, JB, JC,
    input  xpos_out_player2, ypos_out_player2, pos_update, link_up, err_cnt
  );

  // slave: the receive controller
  modport slave (
    input  JA, JB, JC,
    output xpos_out_player2, ypos_out_player2, pos_update, link_up, err_cnt
  );
endinterface

// File: rtl/bus_sync.sv
// Generic N-bit multi-flop synchroniser for quasi-static buses, async reset.
module bus_sync #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/player2_link_rx.sv
// Player-2 position receiver: synchronises the PMOD word, waits for it to settle,
// range-checks it and commits it to the position outputs while tracking link health.
module player2_link_rx
  import air_hockey_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CNT     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 6_500_000,
  parameter int unsigned X_MAX          = SCREEN_X_MAX,
  parameter int unsigned Y_MAX          = SCREEN_Y_MAX
) (
  input logic              clk,
  input logic              rst,
  player2_link_rx_if.slave link
);

  localparam int unsigned MW = $clog2(STABLE_CNT) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  link_word_t       w;
  link_word_t       cand;
  logic [MW-1:0]    match_cnt;
  logic [TW-1:0]    timer;
  logic             err_seen;
  logic [ERR_W-1:0] err_cnt_r;
  link_state_t      state;
  logic [POS_W-1:0] xpos_r;
  logic [POS_W-1:0] ypos_r;
  logic             pos_update_r;
  logic             link_up_r;

  pos_t cand_pos_c;
  logic stable_c;
  logic in_range_c;
  logic q_c;

  bus_sync #(
    .WIDTH  (WORD_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({link.JA, link.JB, link.JC}),
    .q   (w)
  );

  assign cand_pos_c = unpack_pos(cand);
  assign stable_c   = (match_cnt == MW'(STABLE_CNT - 1));
  assign in_range_c = (cand_pos_c.x <= POS_W'(X_MAX)) && (cand_pos_c.y <= POS_W'(Y_MAX));
  assign q_c        = stable_c && in_range_c;

  // Candidate tracking: restart the match count whenever the synced word moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand      <= '0;
      match_cnt <= '0;
    end else if (w != cand) begin
      cand      <= w;
      match_cnt <= '0;
    end else if (!stable_c) begin
      match_cnt <= match_cnt + MW'(1);
    end
  end

  // Out-of-range words are counted once per candidate, not once per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= '0;
      err_seen  <= 1'b0;
    end else begin
      if (stable_c && !in_range_c && !err_seen && (err_cnt_r != '1))
        err_cnt_r <= err_cnt_r + ERR_W'(1);
      if (w != cand)
        err_seen <= 1'b0;
      else if (stable_c && !in_range_c)
        err_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SEARCH;
      timer        <= '0;
      xpos_r       <= '0;
      ypos_r       <= '0;
      pos_update_r <= 1'b0;
      link_up_r    <= 1'b0;
    end else begin
      pos_update_r <= 1'b0;
      case (state)
        SEARCH: begin
          if (q_c) begin
            xpos_r       <= cand_pos_c.x;
            ypos_r       <= cand_pos_c.y;
            pos_update_r <= 1'b1;
            link_up_r    <= 1'b1;
            timer        <= '0;
            state        <= LOCKED;
          end
        end
        LOCKED: begin
          // A qualified word always refreshes the link, even on the timeout cycle
          if (q_c) begin
            timer <= '0;
            if (cand_pos_c != {xpos_r, ypos_r}) begin
              xpos_r       <= cand_pos_c.x;
              ypos_r       <= cand_pos_c.y;
              pos_update_r <= 1'b1;
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            timer     <= '0;
            link_up_r <= 1'b0;
            state     <= SEARCH;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state     <= SEARCH;
          link_up_r <= 1'b0;
        end
      endcase
    end
  end

  assign link.xpos_out_player2 = xpos_r;
  assign link.ypos_out_player2 = ypos_r;
  assign link.pos_update       = pos_update_r;
  assign link.link_up          = link_up_r;
  assign link.err_cnt          = err_cnt_r;

endmodule
